// File: rtl/snake_led_frame_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snake_led_frame_renderer: snake playfield bitmap + splash mux, 16x16 LED |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module snake_led_frame_renderer (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw_out,
  input  logic [7:0]  food,
  input  logic [4:0]  snake_len,
  input  logic [7:0]  snake_0,
  input  logic [7:0]  snake_1,
  input  logic [7:0]  snake_2,
  input  logic [7:0]  snake_3,
  input  logic [7:0]  snake_4,
  input  logic [7:0]  snake_5,
  input  logic [7:0]  snake_6,
  input  logic [7:0]  snake_7,
  input  logic [7:0]  snake_8,
  input  logic [7:0]  snake_9,
  input  logic        display,
  input  logic        draw_start,
  input  logic        draw_win,
  input  logic        draw_over,
  output logic [15:0] y1,
  output logic [15:0] y2,
  output logic [15:0] y3,
  output logic [15:0] y4,
  output logic [15:0] y5,
  output logic [15:0] y6,
  output logic [15:0] y7,
  output logic [15:0] y8,
  output logic [15:0] y9,
  output logic [15:0] y10,
  output logic [15:0] y11,
  output logic [15:0] y12,
  output logic [15:0] y13,
  output logic [15:0] y14,
  output logic [15:0] y15,
  output logic [15:0] y16,
  output logic [15:0] LED_R1,
  output logic [15:0] LED_R2,
  output logic [15:0] LED_R3,
  output logic [15:0] LED_R4,
  output logic [15:0] LED_R5,
  output logic [15:0] LED_R6,
  output logic [15:0] LED_R7,
  output logic [15:0] LED_R8,
  output logic [15:0] LED_R9,
  output logic [15:0] LED_R10,
  output logic [15:0] LED_R11,
  output logic [15:0] LED_R12,
  output logic [15:0] LED_R13,
  output logic [15:0] LED_R14,
  output logic [15:0] LED_R15,
  output logic [15:0] LED_R16
);

  localparam int MAX_LEN = 10;
  localparam int ROWS    = 16;
  localparam int COLS    = 16;

  logic [7:0]      seg [MAX_LEN];
  logic [4:0]      eff_len;
  logic [COLS-1:0] frame_d [ROWS];
  logic [COLS-1:0] frame_q [ROWS];
  logic [COLS-1:0] led_d   [ROWS];
  logic [COLS-1:0] led_q   [ROWS];
  logic [COLS-1:0] start_pat [ROWS];
  logic [COLS-1:0] win_pat   [ROWS];
  logic [COLS-1:0] over_pat  [ROWS];

  assign seg[0] = snake_0;
  assign seg[1] = snake_1;
  assign seg[2] = snake_2;
  assign seg[3] = snake_3;
  assign seg[4] = snake_4;
  assign seg[5] = snake_5;
  assign seg[6] = snake_6;
  assign seg[7] = snake_7;
  assign seg[8] = snake_8;
  assign seg[9] = snake_9;

  // Lengths beyond the segment count saturate rather than wrap
  assign eff_len = (snake_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : snake_len;

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_splash
      assign start_pat[r] = (r == 0 || r == ROWS - 1) ? 16'hFFFF : 16'h8001;
      assign win_pat[r]   = (r % 2 == 0) ? 16'hAAAA : 16'h5555;
      assign over_pat[r]  = (16'h0001 << r) | (16'h0001 << (COLS - 1 - r));
    end
  endgenerate

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      frame_d[r] = frame_q[r];
    end
    if (draw_out) begin
      for (int r = 0; r < ROWS; r++) begin
        frame_d[r] = '0;
      end
      frame_d[food[7:4]][food[3:0]] = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (5'(i) < eff_len) begin
          frame_d[seg[i][7:4]][seg[i][3:0]] = 1'b1;
        end
      end
    end
  end

  // Nested if keeps lower-priority selects out of the decision once a higher one wins
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      led_d[r] = '0;
      if (!display) begin
        led_d[r] = frame_q[r];
      end else if (draw_start) begin
        led_d[r] = start_pat[r];
      end else if (draw_win) begin
        led_d[r] = win_pat[r];
      end else if (draw_over) begin
        led_d[r] = over_pat[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (reset) begin
        frame_q[r] <= '0;
        led_q[r]   <= '0;
      end else begin
        frame_q[r] <= frame_d[r];
        led_q[r]   <= led_d[r];
      end
    end
  end

  assign y1  = frame_q[0];
  assign y2  = frame_q[1];
  assign y3  = frame_q[2];
  assign y4  = frame_q[3];
  assign y5  = frame_q[4];
  assign y6  = frame_q[5];
  assign y7  = frame_q[6];
  assign y8  = frame_q[7];
  assign y9  = frame_q[8];
  assign y10 = frame_q[9];
  assign y11 = frame_q[10];
  assign y12 = frame_q[11];
  assign y13 = frame_q[12];
  assign y14 = frame_q[13];
  assign y15 = frame_q[14];
  assign y16 = frame_q[15];

  assign LED_R1  = led_q[0];
  assign LED_R2  = led_q[1];
  assign LED_R3  = led_q[2];
  assign LED_R4  = led_q[3];
  assign LED_R5  = led_q[4];
  assign LED_R6  = led_q[5];
  assign LED_R7  = led_q[6];
  assign LED_R8  = led_q[7];
  assign LED_R9  = led_q[8];
  assign LED_R10 = led_q[9];
  assign LED_R11 = led_q[10];
  assign LED_R12 = led_q[11];
  assign LED_R13 = led_q[12];
  assign LED_R14 = led_q[13];
  assign LED_R15 = led_q[14];
  assign LED_R16 = led_q[15];

endmodule
`default_nettype wire

// File: tb/tb_snake_led_frame_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_snake_led_frame_renderer: directed bench for snake_led_frame_renderer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_snake_led_frame_renderer;

  logic        clk = 1'b0;
  logic        reset, draw_out, display, draw_start, draw_win, draw_over;
  logic [7:0]  food;
  logic [4:0]  snake_len;
  logic [7:0]  s [10];
  logic [15:0] y [16];
  logic [15:0] led [16];
  logic [15:0] exp_y [16];
  logic [15:0] exp_led [16];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  snake_led_frame_renderer dut (
    .clk(clk), .reset(reset), .draw_out(draw_out), .food(food), .snake_len(snake_len),
    .snake_0(s[0]), .snake_1(s[1]), .snake_2(s[2]), .snake_3(s[3]), .snake_4(s[4]),
    .snake_5(s[5]), .snake_6(s[6]), .snake_7(s[7]), .snake_8(s[8]), .snake_9(s[9]),
    .display(display), .draw_start(draw_start), .draw_win(draw_win), .draw_over(draw_over),
    .y1(y[0]), .y2(y[1]), .y3(y[2]), .y4(y[3]), .y5(y[4]), .y6(y[5]), .y7(y[6]), .y8(y[7]),
    .y9(y[8]), .y10(y[9]), .y11(y[10]), .y12(y[11]), .y13(y[12]), .y14(y[13]),
    .y15(y[14]), .y16(y[15]),
    .LED_R1(led[0]), .LED_R2(led[1]), .LED_R3(led[2]), .LED_R4(led[3]),
    .LED_R5(led[4]), .LED_R6(led[5]), .LED_R7(led[6]), .LED_R8(led[7]),
    .LED_R9(led[8]), .LED_R10(led[9]), .LED_R11(led[10]), .LED_R12(led[11]),
    .LED_R13(led[12]), .LED_R14(led[13]), .LED_R15(led[14]), .LED_R16(led[15])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_y(input string step);
    for (int r = 0; r < 16; r++) chk($sformatf("%s y%0d", step, r + 1), y[r], exp_y[r]);
  endtask

  task automatic chk_led(input string step);
    for (int r = 0; r < 16; r++) chk($sformatf("%s LED_R%0d", step, r + 1), led[r], exp_led[r]);
  endtask

  task automatic clear_exp();
    for (int r = 0; r < 16; r++) begin
      exp_y[r]   = 16'h0000;
      exp_led[r] = 16'h0000;
    end
  endtask

  initial begin
    reset = 1'b1; draw_out = 1'b0; display = 1'b0;
    draw_start = 1'b0; draw_win = 1'b0; draw_over = 1'b0;
    food = 8'h00; snake_len = 5'd0;
    for (int i = 0; i < 10; i++) s[i] = 8'h00;

    // Reset
    tick();
    clear_exp();
    chk_y("reset");
    chk_led("reset");

    // Start splash; other selects and game inputs arbitrary
    reset = 1'b0; display = 1'b1; draw_start = 1'b1; draw_win = 1'b1; draw_over = 1'b1;
    food = 8'hA3; snake_len = 5'd4;
    tick();
    clear_exp();
    exp_led[0] = 16'hFFFF; exp_led[15] = 16'hFFFF;
    for (int r = 1; r < 15; r++) exp_led[r] = 16'h8001;
    chk_led("start");
    chk_y("start");

    // Game frame: snake along row 0 cols 15..6, food at (5,5)
    display = 1'b0; draw_start = 1'b0; draw_win = 1'b0; draw_over = 1'b0;
    draw_out = 1'b1; food = 8'h55; snake_len = 5'd10;
    for (int i = 0; i < 10; i++) s[i] = 8'(8'h0F - i);
    tick();
    clear_exp();
    exp_y[0] = 16'hFFC0; exp_y[5] = 16'h0020;
    chk_y("frame");
    chk_led("frame_lag");
    tick();
    for (int r = 0; r < 16; r++) exp_led[r] = exp_y[r];
    chk_led("frame_led");

    // Hold: segments change but draw_out low
    draw_out = 1'b0;
    s[0] = 8'h07; s[1] = 8'h06; s[2] = 8'h05; s[3] = 8'h04;
    for (int i = 4; i < 10; i++) s[i] = 8'h00;
    tick();
    chk_y("hold");
    chk_led("hold");

    // Redraw
    draw_out = 1'b1;
    tick();
    clear_exp();
    exp_y[0] = 16'h00F1; exp_y[5] = 16'h0020;
    chk_y("redraw");

    // Length masking: segments 2..9 at (15,15) must be ignored
    snake_len = 5'd2; s[0] = 8'h00; s[1] = 8'h01;
    for (int i = 2; i < 10; i++) s[i] = 8'hFF;
    tick();
    clear_exp();
    exp_y[0] = 16'h0003; exp_y[5] = 16'h0020;
    chk_y("lenmask");

    // snake_len above 10 saturates to 10 (all ten at (15,15))
    snake_len = 5'd31;
    tick();
    clear_exp();
    exp_y[0] = 16'h0003; exp_y[5] = 16'h0020; exp_y[15] = 16'h8000;
    chk_y("lensat");

    // snake_len = 0: food only
    snake_len = 5'd0;
    tick();
    clear_exp();
    exp_y[5] = 16'h0020;
    chk_y("len0");

    // Food overlapping the head, plus a duplicate segment
    food = 8'h3C; snake_len = 5'd3; s[0] = 8'h3C; s[1] = 8'h3C; s[2] = 8'hE1;
    tick();
    clear_exp();
    exp_y[3] = 16'h1000; exp_y[14] = 16'h0002;
    chk_y("overlap");

    // Win splash; draw_over also high but lower priority
    draw_out = 1'b0; display = 1'b1; draw_win = 1'b1; draw_over = 1'b1;
    tick();
    for (int r = 0; r < 16; r++) exp_led[r] = (r % 2 == 0) ? 16'hAAAA : 16'h5555;
    chk_led("win");

    // Start outranks win
    draw_start = 1'b1;
    tick();
    chk("prio LED_R1", led[0], 16'hFFFF);
    chk("prio LED_R2", led[1], 16'h8001);

    // Over splash
    draw_start = 1'b0; draw_win = 1'b0;
    tick();
    exp_led[0] = 16'h8001; exp_led[1] = 16'h4002; exp_led[2] = 16'h2004;
    exp_led[3] = 16'h1008; exp_led[4] = 16'h0810; exp_led[5] = 16'h0420;
    exp_led[6] = 16'h0240; exp_led[7] = 16'h0180;
    for (int r = 8; r < 16; r++) exp_led[r] = exp_led[15 - r];
    chk_led("over");

    // No select asserted -> blank
    draw_over = 1'b0;
    tick();
    for (int r = 0; r < 16; r++) exp_led[r] = 16'h0000;
    chk_led("nosel");

    // Reset mid-splash clears both stages
    draw_over = 1'b1;
    tick();
    chk("over_again LED_R8", led[7], 16'h0180);
    reset = 1'b1;
    tick();
    clear_exp();
    chk_y("midreset");
    chk_led("midreset");

    // After release with no draw_out the frame stays blank
    reset = 1'b0; display = 1'b0; draw_over = 1'b0;
    tick();
    tick();
    chk_y("post");
    chk_led("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_led_frame_renderer.md
Name: snake_led_frame_renderer

Overview:
- Renders the snake-game playfield and the splash screens onto a 16x16 LED matrix.
- The game-frame stage rebuilds a 16-row bitmap from the food and snake-segment coordinates whenever the game controller strobes draw_out.
- The output mux stage drives the LED row buses from either that frame or a fixed splash pattern (start / win / game-over).
- Sits between the game FSM and the LED matrix scan driver.

Parameters:
- MAX_LEN, 10, number of snake segment inputs; fixed, not overridable.
- ROWS, 16, matrix rows; fixed.
- COLS, 16, matrix columns; fixed.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all registers
- draw_out  in  1  frame rebuild strobe/level from game FSM
- food  in  8  food coordinate: [7:4]=row 0..15, [3:0]=column 0..15
- snake_len  in  5  number of valid segments (0..10)
- snake_0..snake_9  in  8 each  segment coordinates, same format as food; snake_0 = head
- display  in  1  0=show game frame, 1=show splash
- draw_start  in  1  select start splash
- draw_win  in  1  select win splash
- draw_over  in  1  select game-over splash
- y1..y16  out  16 each  registered game frame; y(r+1) = row r; bit c = column c
- LED_R1..LED_R16  out  16 each  registered LED row data, same row/bit mapping

Behaviour:
Game frame:
- On a rising clk edge with reset=1: y1..y16 <= 0.
- Else, if draw_out=1: every row is rebuilt from scratch (previous contents discarded).
  - Set bit food[3:0] of row food[7:4].
  - For each i < min(snake_len,10), set bit snake_i[3:0] of row snake_i[7:4].
  - All other bits are 0.
  - Overlaps (food on snake, duplicate segments) are OR'd.
- Else (draw_out=0): y1..y16 hold.
- Latency: inputs sampled at edge k appear on y at edge k.
- While draw_out stays high, the frame is rebuilt every cycle.
- Segment inputs at index >= snake_len are ignored regardless of value.
- snake_len > 10 is treated as 10. snake_len = 0 gives a frame with food only.

Output mux, registered, one cycle after y:
- reset=1: LED_R1..16 <= 0.
- display=0: LED_Rn <= yn.
- display=1: splash selected with priority draw_start > draw_win > draw_over; none asserted gives all rows 0.
  - START (border): rows 0 and 15 = 0xFFFF; rows 1..14 = 0x8001.
  - WIN (checkerboard): even rows = 0xAAAA; odd rows = 0x5555.
  - OVER (X): row r has bits r and 15-r set (row 0 = 0x8001, row 7 = 0x0180, row 8 = 0x0180, row 15 = 0x8001).
- X/unknown draw_win/draw_over must not affect output when a higher-priority select is 1, or when display=0.

Timing and reset:
- Total latency draw_out -> LED: 2 clock edges.
- Splash switch latency: 1 edge.
- Reset asserted mid-operation clears both stages on the same edge.
- After reset release, LED shows 0 until the next edge with valid selects.
- The game frame stays 0 until the next draw_out.

Test Plan:
- Reset: reset=1 for 1 edge -> all y and LED_R = 0x0000.
- Start splash: display=1, draw_start=1, other inputs arbitrary -> after 1 edge LED_R1=0xFFFF, LED_R2..R15=0x8001, LED_R16=0xFFFF.
- Game frame: display=0, draw_out=1, food=0x55, snake_len=10, snake_0..9=0x0F,0x0E,...,0x06 -> y1=0xFFC0, y6=0x0020, others 0; LED_R matches one edge later.
- Hold then redraw:
  - Set draw_out=0 and change segments to 0x07,0x06,0x05,0x04,0x00 x6 -> y unchanged.
  - Then draw_out=1 -> y1=0x00F1, y6=0x0020.
- Length masking: snake_len=2, snake_0=0x00, snake_1=0x01, snake_2..9=0xFF, food=0x55 -> y1=0x0003, y16 bit15 clear, y6=0x0020.
- Splash priority: display=1, draw_win=1 -> LED_R1=0xAAAA, LED_R2=0x5555; then draw_win=0, draw_over=1 -> LED_R1=0x8001, LED_R8=0x0180; assert reset mid-splash -> all 0 next edge.
